// File: rtl/st7735_rx.sv
// Receive-side ST7735 4-wire SPI link: synchronizes CS/LCD_CLK/MOSI/DC, rebuilds bytes and,
// when ST7735_RX_PIXEL_EN is defined, decodes CASET/RASET/RAMWR into addressed RGB565 pixels.
module st7735_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        SYSTEM_CLK,
  input  logic        RESET,
  input  logic        CS,
  input  logic        MOSI,
  input  logic        DC,
  input  logic        LCD_CLK,
  input  logic        LCD_RESET,
  output logic [7:0]  BYTE,
  output logic        BYTE_IS_DATA,
  output logic        BYTE_VALID,
  output logic        FRAME_ERR,
  output logic [7:0]  LAST_CMD,
  output logic [15:0] PIXEL,
  output logic [7:0]  PIXEL_X,
  output logic [7:0]  PIXEL_Y,
  output logic        PIXEL_VALID
);

  localparam int unsigned S = SYNC_STAGES;

  // Bit 0 is the newest sample; CS/LCD_CLK carry one extra history flop for edge detection.
  logic [S+1:0] cs_sync_q, clk_sync_q;
  logic [S:0]   mosi_sync_q, dc_sync_q;
  logic [S-1:0] lrst_sync_q;

  always_ff @(posedge SYSTEM_CLK) begin
    if (RESET) begin
      cs_sync_q   <= '1;
      clk_sync_q  <= '0;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      lrst_sync_q <= '1;
    end else begin
      cs_sync_q   <= {cs_sync_q[S:0], CS};
      clk_sync_q  <= {clk_sync_q[S:0], LCD_CLK};
      mosi_sync_q <= {mosi_sync_q[S-1:0], MOSI};
      dc_sync_q   <= {dc_sync_q[S-1:0], DC};
      lrst_sync_q <= {lrst_sync_q[S-2:0], LCD_RESET};
    end
  end

  logic rst_all, cs_prev, cs_rise, cs_fall, clk_rise, shift_en, byte_done, dc_s;
  logic [7:0] rx_byte;

  assign rst_all   = RESET | ~lrst_sync_q[S-1];
  assign cs_prev   = cs_sync_q[S+1];
  assign cs_rise   = cs_sync_q[S] & ~cs_prev;
  assign cs_fall   = ~cs_sync_q[S] & cs_prev;
  assign clk_rise  = clk_sync_q[S] & ~clk_sync_q[S+1];
  // Gating on the previous CS lets a final bit land in the same cycle CS is seen rising.
  assign shift_en  = clk_rise & ~cs_prev;
  assign dc_s      = dc_sync_q[S];

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d, last_cmd_q, last_cmd_d;
  logic       byte_is_data_q, byte_is_data_d, byte_valid_q, frame_err_q, frame_err_d;

  assign rx_byte   = {shift_q, mosi_sync_q[S]};
  assign byte_done = shift_en & (bit_cnt_q == 3'd7);

  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    byte_d         = byte_q;
    byte_is_data_d = byte_is_data_q;
    last_cmd_d     = last_cmd_q;
    frame_err_d    = cs_rise & (bit_cnt_q != 3'd0) & ~byte_done;
    if (cs_fall) begin
      bit_cnt_d = 3'd0;
      shift_d   = '0;
    end else if (shift_en) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = rx_byte[6:0];
    end
    if (cs_rise) bit_cnt_d = 3'd0;
    if (byte_done) begin
      byte_d         = rx_byte;
      byte_is_data_d = dc_s;
      if (!dc_s) last_cmd_d = rx_byte;
    end
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (rst_all) begin
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      byte_q         <= '0;
      byte_is_data_q <= 1'b0;
      byte_valid_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      last_cmd_q     <= '0;
    end else begin
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      byte_q         <= byte_d;
      byte_is_data_q <= byte_is_data_d;
      byte_valid_q   <= byte_done;
      frame_err_q    <= frame_err_d;
      last_cmd_q     <= last_cmd_d;
    end
  end

  assign BYTE         = byte_q;
  assign BYTE_IS_DATA = byte_is_data_q;
  assign BYTE_VALID   = byte_valid_q;
  assign FRAME_ERR    = frame_err_q;
  assign LAST_CMD     = last_cmd_q;

`ifdef ST7735_RX_PIXEL_EN
  logic [7:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [7:0]  x_q, x_d, y_q, y_d, hi_q, hi_d;
  logic [15:0] pixel_q, pixel_d;
  logic        pixel_valid_q, pixel_valid_d, phase_q, phase_d;
  logic [2:0]  idx_q, idx_d;

  always_comb begin
    xs_d = xs_q; xe_d = xe_q; ys_d = ys_q; ye_d = ye_q;
    x_d = x_q; y_d = y_q; hi_d = hi_q; pixel_d = pixel_q;
    phase_d = phase_q; idx_d = idx_q;
    pixel_valid_d = 1'b0;
    // The pointer advances the cycle after the strobe so PIXEL_X/Y show the pixel's address.
    if (pixel_valid_q) begin
      if (x_q == xe_q) begin
        x_d = xs_q;
        y_d = (y_q == ye_q) ? ys_q : y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
    if (byte_done && !dc_s) begin
      idx_d   = 3'd0;
      phase_d = 1'b0;
      case (rx_byte)
        8'h2C: begin x_d = xs_q; y_d = ys_q; end
        8'h01: begin xs_d = 8'd0; xe_d = 8'd127; ys_d = 8'd0; ye_d = 8'd159; end
        default: ;
      endcase
    end else if (byte_done) begin
      if (idx_q != 3'd4) idx_d = idx_q + 3'd1;
      case (last_cmd_q)
        8'h2A: begin
          if (idx_q == 3'd1) xs_d = rx_byte;
          if (idx_q == 3'd3) xe_d = rx_byte;
        end
        8'h2B: begin
          if (idx_q == 3'd1) ys_d = rx_byte;
          if (idx_q == 3'd3) ye_d = rx_byte;
        end
        8'h2C: begin
          if (!phase_q) begin
            hi_d    = rx_byte;
            phase_d = 1'b1;
          end else begin
            pixel_d       = {hi_q, rx_byte};
            pixel_valid_d = 1'b1;
            phase_d       = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (cs_rise) phase_d = 1'b0;
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (rst_all) begin
      xs_q <= 8'd0; xe_q <= 8'd127; ys_q <= 8'd0; ye_q <= 8'd159;
      x_q <= '0; y_q <= '0; hi_q <= '0; pixel_q <= '0;
      pixel_valid_q <= 1'b0; phase_q <= 1'b0; idx_q <= '0;
    end else begin
      xs_q <= xs_d; xe_q <= xe_d; ys_q <= ys_d; ye_q <= ye_d;
      x_q <= x_d; y_q <= y_d; hi_q <= hi_d; pixel_q <= pixel_d;
      pixel_valid_q <= pixel_valid_d; phase_q <= phase_d; idx_q <= idx_d;
    end
  end

  assign PIXEL       = pixel_q;
  assign PIXEL_X     = x_q;
  assign PIXEL_Y     = y_q;
  assign PIXEL_VALID = pixel_valid_q;
`else
  assign PIXEL       = '0;
  assign PIXEL_X     = '0;
  assign PIXEL_Y     = '0;
  assign PIXEL_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_st7735_rx.sv
// Bench for st7735_rx: directed scenarios plus randomized window/pixel traffic checked against
// a window-arithmetic reference model. Pixel expectations follow ST7735_RX_PIXEL_EN.
module tb_st7735_rx;
  localparam int unsigned Sync = 2;
`ifdef ST7735_RX_PIXEL_EN
  localparam bit PixEn = 1'b1;
`else
  localparam bit PixEn = 1'b0;
`endif

  logic        SYSTEM_CLK = 1'b0;
  logic        RESET, CS, MOSI, DC, LCD_CLK, LCD_RESET;
  logic [7:0]  BYTE, LAST_CMD, PIXEL_X, PIXEL_Y;
  logic        BYTE_IS_DATA, BYTE_VALID, FRAME_ERR, PIXEL_VALID;
  logic [15:0] PIXEL;

  st7735_rx #(.SYNC_STAGES(Sync)) dut (
    .SYSTEM_CLK(SYSTEM_CLK), .RESET(RESET), .CS(CS), .MOSI(MOSI), .DC(DC),
    .LCD_CLK(LCD_CLK), .LCD_RESET(LCD_RESET), .BYTE(BYTE), .BYTE_IS_DATA(BYTE_IS_DATA),
    .BYTE_VALID(BYTE_VALID), .FRAME_ERR(FRAME_ERR), .LAST_CMD(LAST_CMD), .PIXEL(PIXEL),
    .PIXEL_X(PIXEL_X), .PIXEL_Y(PIXEL_Y), .PIXEL_VALID(PIXEL_VALID)
  );

  always #5 SYSTEM_CLK = ~SYSTEM_CLK;

  int total = 0;
  int bad = 0;
  int fe_count = 0;
  int exp_fe = 0;
  logic [8:0]  obs_bytes[$], exp_bytes[$];
  logic [31:0] obs_pix[$], exp_pix[$];

  always @(negedge SYSTEM_CLK) begin
    if (BYTE_VALID) obs_bytes.push_back({BYTE_IS_DATA, BYTE});
    if (PIXEL_VALID) obs_pix.push_back({PIXEL_X, PIXEL_Y, PIXEL});
    if (FRAME_ERR) fe_count++;
  end

  // Reference model: window registers plus pixel ordinal since the last RAMWR.
  int m_cmd, m_idx, m_xs, m_xe, m_ys, m_ye, m_x0, m_y0, m_w, m_h, m_k, m_hi;
  bit m_odd;

  task automatic model_reset();
    m_cmd = 0; m_idx = 0; m_odd = 0; m_k = 0; m_hi = 0;
    m_xs = 0; m_xe = 127; m_ys = 0; m_ye = 159;
    m_x0 = 0; m_y0 = 0; m_w = 128; m_h = 160;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic d);
    int x, y;
    if (!d) begin
      m_cmd = int'(b); m_idx = 0; m_odd = 0;
      if (b == 8'h01) begin m_xs = 0; m_xe = 127; m_ys = 0; m_ye = 159; end
      if (b == 8'h2C) begin
        m_k = 0; m_x0 = m_xs; m_y0 = m_ys;
        m_w = ((m_xe - m_xs) & 255) + 1;
        m_h = ((m_ye - m_ys) & 255) + 1;
      end
    end else begin
      if (m_cmd == 'h2A && m_idx == 1) m_xs = int'(b);
      if (m_cmd == 'h2A && m_idx == 3) m_xe = int'(b);
      if (m_cmd == 'h2B && m_idx == 1) m_ys = int'(b);
      if (m_cmd == 'h2B && m_idx == 3) m_ye = int'(b);
      if (m_cmd == 'h2C) begin
        if (!m_odd) begin
          m_hi = int'(b); m_odd = 1;
        end else begin
          m_odd = 0;
          x = (m_x0 + m_k % m_w) & 255;
          y = (m_y0 + (m_k / m_w) % m_h) & 255;
          if (PixEn) exp_pix.push_back({x[7:0], y[7:0], m_hi[7:0], b});
          m_k++;
        end
      end
      m_idx++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge SYSTEM_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input logic d, input int half, input int n);
    for (int i = 7; i >= 8 - n; i--) begin
      MOSI = b[i]; DC = d;
      tick(half);
      LCD_CLK = 1'b1;
      tick(half);
      LCD_CLK = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic d, input int half);
    spi_bits(b, d, half, 8);
    exp_bytes.push_back({d, b});
    model_byte(b, d);
  endtask

  task automatic cs_low();
    CS = 1'b0;
    tick(3);
  endtask

  task automatic cs_high();
    tick(2);
    CS = 1'b1;
    m_odd = 0;
    tick(3);
  endtask

  task automatic check_stream(input string tag);
    tick(Sync + 6);
    chk({tag, " byte count"}, 32'(obs_bytes.size()), 32'(exp_bytes.size()));
    while (obs_bytes.size() > 0 && exp_bytes.size() > 0)
      chk({tag, " byte"}, 32'(obs_bytes.pop_front()), 32'(exp_bytes.pop_front()));
    chk({tag, " pixel count"}, 32'(obs_pix.size()), 32'(exp_pix.size()));
    while (obs_pix.size() > 0 && exp_pix.size() > 0)
      chk({tag, " pixel"}, obs_pix.pop_front(), exp_pix.pop_front());
    chk({tag, " frame_err"}, 32'(fe_count), 32'(exp_fe));
    obs_bytes.delete(); exp_bytes.delete(); obs_pix.delete(); exp_pix.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " BYTE"}, 32'(BYTE), 32'h0);
    chk({tag, " BYTE_IS_DATA"}, 32'(BYTE_IS_DATA), 32'h0);
    chk({tag, " BYTE_VALID"}, 32'(BYTE_VALID), 32'h0);
    chk({tag, " FRAME_ERR"}, 32'(FRAME_ERR), 32'h0);
    chk({tag, " LAST_CMD"}, 32'(LAST_CMD), 32'h0);
    chk({tag, " PIXEL"}, 32'(PIXEL), 32'h0);
    chk({tag, " PIXEL_X"}, 32'(PIXEL_X), 32'h0);
    chk({tag, " PIXEL_Y"}, 32'(PIXEL_Y), 32'h0);
    chk({tag, " PIXEL_VALID"}, 32'(PIXEL_VALID), 32'h0);
  endtask

  initial begin
    int half, npix, xs, ys;
    logic [7:0] cmds[4];
    cmds[0] = 8'h11; cmds[1] = 8'h29; cmds[2] = 8'h36; cmds[3] = 8'h3A;
    RESET = 1'b1; CS = 1'b1; MOSI = 1'b0; DC = 1'b0; LCD_CLK = 1'b0; LCD_RESET = 1'b1;
    model_reset();
    tick(4);
    RESET = 1'b0;
    tick(1);
    check_reset("reset");

    // RAMWR with one pixel at the default window origin.
    cs_low();
    spi_byte(8'h2C, 1'b0, 2);
    spi_byte(8'hF8, 1'b1, 2);
    spi_byte(8'h00, 1'b1, 2);
    cs_high();
    check_stream("first");
    chk("first LAST_CMD", 32'(LAST_CMD), 32'h2C);

    // 2x2 window at (2..3, 5..6) with wrap back to the origin.
    cs_low();
    spi_byte(8'h2A, 1'b0, 2); spi_byte(8'h00, 1'b1, 2); spi_byte(8'h02, 1'b1, 2);
    spi_byte(8'h00, 1'b1, 2); spi_byte(8'h03, 1'b1, 2);
    spi_byte(8'h2B, 1'b0, 2); spi_byte(8'h00, 1'b1, 2); spi_byte(8'h05, 1'b1, 2);
    spi_byte(8'h00, 1'b1, 2); spi_byte(8'h06, 1'b1, 2);
    spi_byte(8'h2C, 1'b0, 2);
    for (int i = 0; i < 10; i++) spi_byte(8'(8'h10 + i), 1'b1, 2);
    cs_high();
    check_stream("window");

    // Partial byte then a clean byte.
    cs_low();
    spi_bits(8'hA0, 1'b1, 2, 5);
    cs_high();
    exp_fe++;
    check_stream("frame_err");
    cs_low();
    spi_byte(8'hA5, 1'b1, 2);
    cs_high();
    check_stream("after frame_err");

    // CS rises together with the 8th clock edge: byte completes, no frame error.
    cs_low();
    spi_bits(8'h96, 1'b1, 2, 7);
    MOSI = 1'b0; DC = 1'b1;
    tick(2);
    LCD_CLK = 1'b1; CS = 1'b1;
    tick(2);
    LCD_CLK = 1'b0;
    exp_bytes.push_back({1'b1, 8'h96});
    model_byte(8'h96, 1'b1);
    m_odd = 0;
    tick(3);
    check_stream("cs with last bit");

    // BYTE_VALID latency from the first edge sampling LCD_CLK high for bit 0.
    cs_low();
    spi_bits(8'h3C, 1'b0, 2, 7);
    MOSI = 1'b0; DC = 1'b0;
    tick(2);
    LCD_CLK = 1'b1;
    @(posedge SYSTEM_CLK);
    repeat (Sync) @(posedge SYSTEM_CLK);
    #1;
    chk("latency early", 32'(BYTE_VALID), 32'h0);
    @(posedge SYSTEM_CLK);
    #1;
    chk("latency strobe", 32'(BYTE_VALID), 32'h1);
    chk("latency BYTE", 32'(BYTE), 32'h3C);
    tick(2);
    LCD_CLK = 1'b0;
    exp_bytes.push_back({1'b0, 8'h3C});
    model_byte(8'h3C, 1'b0);
    tick(4);
    chk("BYTE held", 32'(BYTE), 32'h3C);
    cs_high();
    check_stream("latency");

    // SWRESET back-to-back with RAMWR, 3 MHz LCD_CLK.
    cs_low();
    spi_byte(8'h01, 1'b0, 2); spi_byte(8'h2C, 1'b0, 2);
    spi_byte(8'h12, 1'b1, 2); spi_byte(8'h34, 1'b1, 2);
    spi_byte(8'hAB, 1'b1, 2); spi_byte(8'hCD, 1'b1, 2);
    cs_high();
    check_stream("swreset");

    // LCD_RESET in the middle of a RAMWR pixel.
    cs_low();
    spi_byte(8'h2C, 1'b0, 2); spi_byte(8'hF8, 1'b1, 2);
    check_stream("pre lcd_reset");
    LCD_RESET = 1'b0;
    tick(4);
    LCD_RESET = 1'b1;
    tick(Sync + 3);
    model_reset();
    check_reset("lcd_reset");
    spi_byte(8'h12, 1'b1, 2); spi_byte(8'h34, 1'b1, 2);
    check_stream("post lcd_reset");
    spi_byte(8'h2C, 1'b0, 2); spi_byte(8'h56, 1'b1, 2); spi_byte(8'h78, 1'b1, 2);
    cs_high();
    check_stream("ramwr after lcd_reset");

    // Randomized windows, filler commands and pixel bursts.
    for (int it = 0; it < 6; it++) begin
      half = $urandom_range(2, 4);
      xs = (it == 0) ? 254 : $urandom_range(0, 255);
      ys = (it == 1) ? 255 : $urandom_range(0, 255);
      cs_low();
      if ($urandom_range(0, 3) == 0) spi_byte(8'h01, 1'b0, half);
      spi_byte(8'h2A, 1'b0, half);
      spi_byte(8'($urandom_range(0, 255)), 1'b1, half);
      spi_byte(8'(xs), 1'b1, half);
      spi_byte(8'($urandom_range(0, 255)), 1'b1, half);
      spi_byte(8'((xs + $urandom_range(0, 3)) & 255), 1'b1, half);
      repeat ($urandom_range(0, 2)) spi_byte(8'($urandom_range(0, 255)), 1'b1, half);
      spi_byte(8'h2B, 1'b0, half);
      spi_byte(8'($urandom_range(0, 255)), 1'b1, half);
      spi_byte(8'(ys), 1'b1, half);
      spi_byte(8'($urandom_range(0, 255)), 1'b1, half);
      spi_byte(8'((ys + $urandom_range(0, 2)) & 255), 1'b1, half);
      if ($urandom_range(0, 1) == 1) begin
        spi_byte(cmds[$urandom_range(0, 3)], 1'b0, half);
        spi_byte(8'($urandom_range(0, 255)), 1'b1, half);
      end
      spi_byte(8'h2C, 1'b0, half);
      npix = $urandom_range(1, 6);
      repeat (2 * npix) spi_byte(8'($urandom_range(0, 255)), 1'b1, half);
      if ($urandom_range(0, 1) == 1) spi_byte(8'($urandom_range(0, 255)), 1'b1, half);
      cs_high();
      check_stream("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/st7735_rx.md
# st7735_rx

Receive-side model of the ST7735 4-wire SPI panel link: oversamples CS/MOSI/DC/LCD_CLK on SYSTEM_CLK, rebuilds command and data bytes, and decodes the CASET/RASET/RAMWR subset into addressed RGB565 pixels. It sits at the far end of the ST7735 driver's pins. It is used in benches and on hardware loopback to check what the driver actually sends.

## Interface
- SYNC_STAGES, 2, flip-flop stages on each SPI input (minimum 2)
- SYSTEM_CLK  in  1  system clock (12 MHz nominal)
- RESET  in  1  one clock; reset is synchronous and active-high
- CS  in  1  chip select, active-low, asynchronous to SYSTEM_CLK
- MOSI  in  1  serial data, MSB first, sampled on LCD_CLK rising (SPI mode 0)
- DC  in  1  0 = command byte, 1 = data byte; sampled with bit 0
- LCD_CLK  in  1  SPI clock from driver
- LCD_RESET  in  1  panel reset pin, active-low; synchronized, same effect as RESET
- BYTE  out  8  last received byte
- BYTE_IS_DATA  out  1  DC value of BYTE
- BYTE_VALID  out  1  one-cycle strobe, BYTE/BYTE_IS_DATA valid
- FRAME_ERR  out  1  one-cycle strobe, CS rose with 1-7 bits shifted
- LAST_CMD  out  8  most recent command byte
- PIXEL  out  16  RGB565 pixel (with ST7735_RX_PIXEL_EN)
- PIXEL_X, PIXEL_Y  out  8 each  pixel address
- PIXEL_VALID  out  1  one-cycle pixel strobe

## Operation
- All SPI inputs pass through SYNC_STAGES flops; edges are detected on the synchronized copies only. Relative order of CS, LCD_CLK, and DC edges is preserved.
- CS falling: bit counter = 0, shift register cleared. While CS is high, LCD_CLK edges are ignored.
- Each synchronized LCD_CLK rise with CS low shifts MOSI in MSB-first. On the 8th rise:
  - BYTE is loaded;
  - BYTE_IS_DATA is loaded from DC;
  - BYTE_VALID pulses;
  - the counter wraps to 0, so back-to-back bytes need no CS toggle.
- CS rising with counter 1-7: the partial byte is discarded, FRAME_ERR pulses, and the counter returns to 0.
- Command byte (DC=0): LAST_CMD is updated, the data index is cleared, and the pixel byte phase is cleared.
- Command decoder (data bytes indexed 0..n after the last command):
  - 0x2A CASET: idx1 -> XS, idx3 -> XE. idx0/idx2 (high bytes) and idx>3 are ignored.
  - 0x2B RASET: idx1 -> YS, idx3 -> YE, same rules as CASET.
  - 0x2C RAMWR: the pointer loads (XS,YS) on the command. Even data byte = PIXEL[15:8]; the following odd byte = PIXEL[7:0], and PIXEL_VALID pulses with the current pointer.
  - Pointer advance after each pixel: if X==XE then X=XS and Y advances; otherwise X=X+1. Y advance: if Y==YE then Y=YS, otherwise Y=Y+1. Arithmetic is 8-bit unsigned.
  - If XS>XE, X increments and wraps at 255 to 0 until it equals XE; Y follows the same rule.
  - 0x01 SWRESET: the window returns to its defaults.
  - A trailing odd RAMWR byte at the next command or CS rise is dropped silently, with no FRAME_ERR.
  - Other commands: data bytes are counted and otherwise ignored.
- RESET or synchronized LCD_RESET low clears all state, including synchronizer flops (RESET only).
- Reset values:
  - BYTE=0, BYTE_IS_DATA=0, BYTE_VALID=0, FRAME_ERR=0, LAST_CMD=0x00;
  - PIXEL=0, PIXEL_X=0, PIXEL_Y=0, PIXEL_VALID=0;
  - XS=0, XE=127, YS=0, YE=159.

## Timing
- LCD_CLK high and low phases must each be at least 2 SYSTEM_CLK periods. MOSI and DC must be stable from 1 period before to 1 period after each LCD_CLK rise.
- BYTE_VALID rises SYNC_STAGES+1 SYSTEM_CLK edges after the first edge that samples LCD_CLK high for bit 0.
- PIXEL_VALID is asserted in the same cycle as the BYTE_VALID of the low byte. PIXEL_X/PIXEL_Y hold the pre-advance pointer during that cycle and advance on the next edge.
- Strobes are exactly one cycle wide. BYTE and PIXEL hold until the next strobe.
- 8th LCD_CLK rise and CS rise detected in the same cycle: the byte completes and there is no FRAME_ERR.
- RESET mid-byte or mid-pixel: outputs take reset values on the next edge and no strobe fires.

## Configuration
- ST7735_RX_PIXEL_EN defined: CASET/RASET/RAMWR decode and the PIXEL* outputs are present.
- ST7735_RX_PIXEL_EN undefined:
  - the window, pointer, and pixel logic are not built;
  - PIXEL, PIXEL_X, and PIXEL_Y are tied 0 and PIXEL_VALID is tied 0;
  - the byte path and LAST_CMD behave identically.

## Test plan
- Reset, then CS low and bytes 0x2C (DC=0), 0xF8, 0x00 (DC=1) -> BYTE_VALID x3 with BYTE_IS_DATA 0,1,1; LAST_CMD=0x2C; PIXEL=0xF800 at (0,0).
- CASET 00 02 00 03, RASET 00 05 00 06, RAMWR with 5 pixels -> addresses (2,5),(3,5),(2,6),(3,6),(2,5).
- CS rises after 5 bits -> FRAME_ERR=1 for one cycle, no BYTE_VALID; the next full byte 0xA5 is received correctly.
- Bytes 0x01, 0x2C, 0x12, 0x34 back-to-back without a CS toggle, LCD_CLK at 3 MHz -> PIXEL=0x1234 at (0,0) and the window is at its defaults.
- LCD_RESET low for 4 cycles mid-RAMWR -> all outputs at reset values; a following odd byte produces no PIXEL_VALID until the next RAMWR command.
- Build without ST7735_RX_PIXEL_EN and rerun the first scenario -> identical BYTE stream, PIXEL_VALID stays 0.
